mm_port_arbiter: RTL

- Arbitrates the single main-memory word port between two line-burst requesters: instruction-cache refill (I) and data-cache refill/writeback (D).
- Sits between the cache controller datapath and main memory.
- Each grant runs a complete WORDS_PER_LINE-word burst, sequencing word addresses and the memory read/write handshake.
- Returns per-beat data/valid and a done pulse to the winning requester.

---
 rtl/mm_port_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/mm_port_arbiter.sv
// mm_port_arbiter: round-robin arbiter running whole line bursts from I/D cache refills onto one memory word port
module mm_port_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                              MEM_CLK,
  input  logic                              RST_N,
  input  logic                              I_REQ,
  input  logic [ADDR_W-1:0]                 I_ADDR,
  output logic [WORD_W-1:0]                 I_RDATA,
  output logic                              I_VALID,
  output logic                              I_DONE,
  input  logic                              D_REQ,
  input  logic                              D_WE,
  input  logic [ADDR_W-1:0]                 D_ADDR,
  input  logic [WORD_W-1:0]                 D_WDATA,
  output logic                              D_WREADY,
  output logic [WORD_W-1:0]                 D_RDATA,
  output logic                              D_VALID,
  output logic                              D_DONE,
  output logic [$clog2(WORDS_PER_LINE)-1:0] BEAT,
  output logic                              MM_RE,
  output logic                              MM_WE,
  output logic [ADDR_W-3:0]                 MM_ADDR,
  output logic [WORD_W-1:0]                 MM_DIN,
  input  logic [WORD_W-1:0]                 MM_DOUT,
  input  logic                              MM_VALID
);
  localparam int LB = $clog2(WORDS_PER_LINE);
  localparam int BW = ADDR_W - 2 - LB;
  typedef enum logic [2:0] {IDLE, BURST_I, BURST_D, DONE_I, DONE_D} state_t;
  state_t state;
  logic [LB-1:0] beat;
  logic [BW-1:0] base;
  logic we;
  logic last_d;
  logic burst;
  logic last;
  logic unused_offset;
  assign burst = (state == BURST_I) || (state == BURST_D);
  assign last = beat == LB'(WORDS_PER_LINE - 1);
  assign unused_offset = ^{I_ADDR[LB+1:0], D_ADDR[LB+1:0]};
  // grant on a request in IDLE, step beats on each completed access, pulse DONE for one cycle
  always_ff @(posedge MEM_CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      beat <= '0;
      base <= '0;
      we <= 1'b0;
      last_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (I_REQ && (!D_REQ || last_d)) begin
            state <= BURST_I;
            base <= I_ADDR[ADDR_W-1:LB+2];
            we <= 1'b0;
            last_d <= 1'b0;
          end else if (D_REQ) begin
            state <= BURST_D;
            base <= D_ADDR[ADDR_W-1:LB+2];
            we <= D_WE;
            last_d <= 1'b1;
          end
        end
        BURST_I, BURST_D: begin
          if (MM_VALID) begin
            beat <= last ? '0 : beat + 1'b1;
            if (last) state <= (state == BURST_I) ? DONE_I : DONE_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // outputs decode from registered state; read data and beat acks follow MM_VALID in the same cycle
  always_comb begin
    MM_RE = burst && !we;
    MM_WE = burst && we;
    MM_ADDR = burst ? {base, beat} : '0;
    MM_DIN = (burst && we) ? D_WDATA : '0;
    BEAT = beat;
    I_VALID = (state == BURST_I) && MM_VALID;
    D_VALID = (state == BURST_D) && !we && MM_VALID;
    D_WREADY = (state == BURST_D) && we && MM_VALID;
    I_RDATA = I_VALID ? MM_DOUT : '0;
    D_RDATA = D_VALID ? MM_DOUT : '0;
    I_DONE = state == DONE_I;
    D_DONE = state == DONE_D;
  end
endmodule
